tap_controller: RTL

TAP_CONTROLLER -- requirements
Module: tap_controller

---
 rtl/tap_controller.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tap_controller.sv
`default_nettype none
// ============================================================================
// Module   : tap_controller
// Brief    : IEEE 1149.1 TAP controller with 2-bit IR, IDCODE and BYPASS
//            registers, and gated ClockDR/UpdateDR for an external boundary chain.
// Revision : 1.0 - initial release
// ============================================================================
module tap_controller #(
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic TCK,
    input  logic TRST_N,
    input  logic TMS,
    input  logic TDI,
    input  logic bsr_tdo,
    output logic ShiftDR,
    output logic ClockDR,
    output logic UpdateDR,
    output logic Mode,
    output logic TDO,
    output logic TDO_EN
);

    localparam logic [3:0] c_TLR    = 4'h0;
    localparam logic [3:0] c_RTI    = 4'h1;
    localparam logic [3:0] c_SEL_DR = 4'h2;
    localparam logic [3:0] c_CAP_DR = 4'h3;
    localparam logic [3:0] c_SH_DR  = 4'h4;
    localparam logic [3:0] c_EX1_DR = 4'h5;
    localparam logic [3:0] c_PAU_DR = 4'h6;
    localparam logic [3:0] c_EX2_DR = 4'h7;
    localparam logic [3:0] c_UPD_DR = 4'h8;
    localparam logic [3:0] c_SEL_IR = 4'h9;
    localparam logic [3:0] c_CAP_IR = 4'hA;
    localparam logic [3:0] c_SH_IR  = 4'hB;
    localparam logic [3:0] c_EX1_IR = 4'hC;
    localparam logic [3:0] c_PAU_IR = 4'hD;
    localparam logic [3:0] c_EX2_IR = 4'hE;
    localparam logic [3:0] c_UPD_IR = 4'hF;

    localparam logic [1:0] c_IR_EXTEST  = 2'b00;
    localparam logic [1:0] c_IR_SAMPLE  = 2'b01;
    localparam logic [1:0] c_IR_IDCODE  = 2'b10;
    localparam logic [1:0] c_IR_BYPASS  = 2'b11;

    logic [3:0]  r_state;
    logic [3:0]  w_next_state;
    logic [1:0]  r_ir_sh;
    logic [1:0]  r_ir;
    logic        r_bypass;
    logic [31:0] r_id;
    logic        r_shift_dr;
    logic        r_clk_en;
    logic        r_upd_en;
    logic        r_tdo;
    logic        r_tdo_en;
    logic        w_bsr_sel;

    // EXTEST and SAMPLE_PRELOAD both route the boundary chain
    assign w_bsr_sel = (r_ir == c_IR_EXTEST) || (r_ir == c_IR_SAMPLE);

    always_comb begin
        w_next_state = c_TLR;
        case (r_state)
            c_TLR:    w_next_state = TMS ? c_TLR    : c_RTI;
            c_RTI:    w_next_state = TMS ? c_SEL_DR : c_RTI;
            c_SEL_DR: w_next_state = TMS ? c_SEL_IR : c_CAP_DR;
            c_CAP_DR: w_next_state = TMS ? c_EX1_DR : c_SH_DR;
            c_SH_DR:  w_next_state = TMS ? c_EX1_DR : c_SH_DR;
            c_EX1_DR: w_next_state = TMS ? c_UPD_DR : c_PAU_DR;
            c_PAU_DR: w_next_state = TMS ? c_EX2_DR : c_PAU_DR;
            c_EX2_DR: w_next_state = TMS ? c_UPD_DR : c_SH_DR;
            c_UPD_DR: w_next_state = TMS ? c_SEL_DR : c_RTI;
            c_SEL_IR: w_next_state = TMS ? c_TLR    : c_CAP_IR;
            c_CAP_IR: w_next_state = TMS ? c_EX1_IR : c_SH_IR;
            c_SH_IR:  w_next_state = TMS ? c_EX1_IR : c_SH_IR;
            c_EX1_IR: w_next_state = TMS ? c_UPD_IR : c_PAU_IR;
            c_PAU_IR: w_next_state = TMS ? c_EX2_IR : c_PAU_IR;
            c_EX2_IR: w_next_state = TMS ? c_UPD_IR : c_SH_IR;
            c_UPD_IR: w_next_state = TMS ? c_SEL_DR : c_RTI;
            default:  w_next_state = c_TLR;
        endcase
    end

    // Rising-edge domain: state, shift stages and update-pulse enable
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_state    <= c_TLR;
            r_ir_sh    <= 2'b01;
            r_bypass   <= 1'b0;
            r_id       <= IDCODE_VAL;
            r_shift_dr <= 1'b0;
            r_upd_en   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_shift_dr <= (w_next_state == c_SH_DR);
            r_upd_en   <= (w_next_state == c_UPD_DR) && w_bsr_sel;
            case (r_state)
                c_CAP_IR: r_ir_sh <= 2'b01;
                c_SH_IR:  r_ir_sh <= {TDI, r_ir_sh[1]};
                c_CAP_DR: begin
                    if (r_ir == c_IR_BYPASS) r_bypass <= 1'b0;
                    if (r_ir == c_IR_IDCODE) r_id     <= IDCODE_VAL;
                end
                c_SH_DR: begin
                    if (r_ir == c_IR_BYPASS) r_bypass <= TDI;
                    if (r_ir == c_IR_IDCODE) r_id     <= {TDI, r_id[31:1]};
                end
                default: ;
            endcase
        end
    end

    // Falling-edge domain: active IR, TDO and the ClockDR enable
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_ir     <= c_IR_IDCODE;
            r_clk_en <= 1'b0;
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_clk_en <= ((r_state == c_CAP_DR) || (r_state == c_SH_DR)) && w_bsr_sel;
            if (r_state == c_TLR) begin
                r_ir <= c_IR_IDCODE;
            end else if (r_state == c_UPD_IR) begin
                r_ir <= r_ir_sh;
            end
            case (r_state)
                c_SH_IR: begin
                    r_tdo    <= r_ir_sh[0];
                    r_tdo_en <= 1'b1;
                end
                c_SH_DR: begin
                    r_tdo_en <= 1'b1;
                    case (r_ir)
                        c_IR_IDCODE: r_tdo <= r_id[0];
                        c_IR_BYPASS: r_tdo <= r_bypass;
                        default:     r_tdo <= bsr_tdo;
                    endcase
                end
                default: begin
                    r_tdo    <= 1'b0;
                    r_tdo_en <= 1'b0;
                end
            endcase
        end
    end

    // Enables only change while the gating clock phase is inactive
    assign ClockDR  = TCK & r_clk_en;
    assign UpdateDR = ~TCK & r_upd_en;
    assign ShiftDR  = r_shift_dr;
    assign Mode     = (r_ir == c_IR_EXTEST);
    assign TDO      = r_tdo;
    assign TDO_EN   = r_tdo_en;

endmodule
`default_nettype wire
